ibuffer: RTL and testbench

//  Instruction buffer between the fetch stage and decode. Accepts one 2-instruction fetch

---
 rtl/core_pkg.sv | 14 +
 rtl/ibuffer.sv | 90 +++++++++
 tb/tb_ibuffer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core types: the fetched_packet carried from fetch through the instruction buffer
// to decode, and the width of a two-instruction fetch group.
package core_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
      logic        taken_branch;
   } fetched_packet;

   localparam int PACKET_W      = $bits(fetched_packet);
   localparam int FETCH_GROUP_W = 2 * PACKET_W;

endpackage

// File: rtl/ibuffer.sv
// Instruction buffer: circular FIFO of single instructions, filled a whole fetch group at a
// time and drained 0, 1 or 2 oldest instructions per cycle by decode.
module ibuffer
   import core_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_in,
   input  logic [FETCH_GROUP_W-1:0] data_in,
   output logic                     ready_o,
   input  logic                     flush,
   output logic                     valid_a_o,
   output fetched_packet            packet_a_o,
   output logic                     valid_b_o,
   output fetched_packet            packet_b_o,
   input  logic                     consume_a,
   input  logic                     consume_b
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] head_reg;
   logic [PTR_W-1:0] tail_reg;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;

   fetched_packet mem [DEPTH];
   fetched_packet pkt_in [2];
   fetched_packet pkt_rd [2];

   logic       enq;
   logic [1:0] deq;

   assign pkt_in[0] = fetched_packet'(data_in[PACKET_W-1:0]);
   assign pkt_in[1] = fetched_packet'(data_in[FETCH_GROUP_W-1:PACKET_W]);

   // Room for a whole group is judged from the registered count only, so decode's
   // consume never reaches fetch's ready combinationally.
   assign ready_o = (count_reg <= CNT_W'(DEPTH - 2));
   assign enq     = valid_in & ready_o & ~flush;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         assign pkt_rd[gi] = mem[head_reg + PTR_W'(gi)];
      end
   endgenerate

   assign valid_a_o  = (count_reg >= CNT_W'(1)) & ~flush;
   assign valid_b_o  = (count_reg >= CNT_W'(2)) & ~flush;
   assign packet_a_o = pkt_rd[0];
   assign packet_b_o = pkt_rd[1];

   // consume_b only counts alongside consume_a; both are masked by output validity.
   assign deq = 2'(consume_a & valid_a_o) + 2'(consume_a & consume_b & valid_b_o);

   assign count_next = count_reg + (enq ? CNT_W'(2) : CNT_W'(0)) - CNT_W'(deq);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else if (flush) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         head_reg  <= head_reg + PTR_W'(deq);
         tail_reg  <= tail_reg + (enq ? PTR_W'(2) : PTR_W'(0));
         count_reg <= count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         mem[tail_reg]            <= pkt_in[0];
         mem[tail_reg + PTR_W'(1)] <= pkt_in[1];
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      count_reg <= CNT_W'(DEPTH));
   a_no_underflow: assert property (@(posedge clk) disable iff (rst)
      CNT_W'(deq) <= count_reg);

endmodule

// File: tb/tb_ibuffer.sv
// Randomized scoreboard bench for ibuffer: a queue of expected instructions is the reference,
// a negedge monitor compares the DUT's presented entries against the queue head.
module tb_ibuffer;
   import core_pkg::*;

   localparam int DEPTH = 8;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     valid_in;
   logic [FETCH_GROUP_W-1:0] data_in;
   logic                     ready_o;
   logic                     flush;
   logic                     valid_a_o;
   fetched_packet            packet_a_o;
   logic                     valid_b_o;
   fetched_packet            packet_b_o;
   logic                     consume_a;
   logic                     consume_b;

   ibuffer #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .valid_in   (valid_in),
      .data_in    (data_in),
      .ready_o    (ready_o),
      .flush      (flush),
      .valid_a_o  (valid_a_o),
      .packet_a_o (packet_a_o),
      .valid_b_o  (valid_b_o),
      .packet_b_o (packet_b_o),
      .consume_a  (consume_a),
      .consume_b  (consume_b)
   );

   always #5 clk = ~clk;

   fetched_packet exp_q [$];
   int            checks = 0;
   int            passed = 0;
   logic          done = 1'b0;

   logic          pend_enq;
   logic          pend_flush;
   fetched_packet pend_a;
   fetched_packet pend_b;
   logic [31:0]   next_pc;

   task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
   endtask

   // Monitor: compare presented outputs against the queue, then retire what decode takes.
   int  sz;
   logic exp_va, exp_vb;
   always @(negedge clk) begin
      if (!done) begin
         sz     = exp_q.size();
         exp_va = (sz >= 1) && !flush;
         exp_vb = (sz >= 2) && !flush;
         check("ready_o", 65'(ready_o), 65'(sz <= DEPTH - 2));
         check("valid_a_o", 65'(valid_a_o), 65'(exp_va));
         check("valid_b_o", 65'(valid_b_o), 65'(exp_vb));
         if (exp_va) check("packet_a_o", packet_a_o, exp_q[0]);
         if (exp_vb) check("packet_b_o", packet_b_o, exp_q[1]);
         if (!rst && !flush && consume_a && sz >= 1) begin
            void'(exp_q.pop_front());
            if (consume_b && sz >= 2) void'(exp_q.pop_front());
         end
      end
   end

   // Driver: commit last cycle's accepted group or flush, then issue new random inputs.
   initial begin
      fetched_packet a, b;
      int pv, pcons;
      rst = 1'b1; valid_in = 1'b0; flush = 1'b0; consume_a = 1'b0; consume_b = 1'b0;
      data_in = '0; pend_enq = 1'b0; pend_flush = 1'b0; next_pc = 32'h100;
      pend_a = '0; pend_b = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk);
         #1;
         if (pend_flush) exp_q.delete();
         else if (pend_enq) begin
            exp_q.push_back(pend_a);
            exp_q.push_back(pend_b);
         end
         pend_enq = 1'b0;
         pend_flush = 1'b0;
         rst = 1'b0;
         if (cyc == 1500 || cyc == 2400) begin
            rst = 1'b1;
            exp_q.delete();
            valid_in = 1'b0; flush = 1'b0; consume_a = 1'b0; consume_b = 1'b0;
            continue;
         end
         case ((cyc / 150) % 3)
            0:       begin pv = 90; pcons = 15; end
            1:       begin pv = 60; pcons = 60; end
            default: begin pv = 30; pcons = 90; end
         endcase
         a.pc = next_pc;      a.data = $urandom; a.taken_branch = 1'($urandom_range(0, 1));
         b.pc = next_pc + 4;  b.data = $urandom; b.taken_branch = 1'($urandom_range(0, 1));
         data_in   = {b, a};
         valid_in  = ($urandom_range(0, 99) < pv);
         consume_a = ($urandom_range(0, 99) < pcons);
         consume_b = 1'($urandom_range(0, 1));
         flush     = ($urandom_range(0, 99) < 3);
         if (valid_in && !flush && exp_q.size() <= DEPTH - 2) begin
            pend_enq = 1'b1;
            pend_a   = a;
            pend_b   = b;
            next_pc  = next_pc + 8;
         end
         pend_flush = flush;
      end
      @(posedge clk);
      #1 done = 1'b1;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
